// File: rtl/bar_sweep_pkg.sv
// Shared types and default constants for the vertical inverted-bar sweep controller.
package bar_sweep_pkg;

    typedef enum logic [1:0] {
        StSync,
        StBlank,
        StActive
    } sweep_state_e;

    // Bit positions inside the fvht timing flag bus.
    localparam int unsigned FVHT_V_BIT = 2;
    localparam int unsigned FVHT_H_BIT = 1;

    // Sweep bounds and start line.
    localparam int unsigned DEF_MIN_POS   = 1;
    localparam int unsigned DEF_MAX_POS   = 1024;
    localparam int unsigned DEF_RESET_POS = 2;

    // Frame configuration used until the first frame end latches real values.
    localparam int unsigned DEF_SHADOW_STEP   = 1;
    localparam int unsigned DEF_SHADOW_HEIGHT = 8;

endpackage

// File: rtl/sync_edge_detect.sv
// Rise/fall strobe generator for a level that is already synchronous to i_clk.
// The strobe is seen by the clock edge that first samples the new level.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic sig_q;
    logic sig_d;

    // Remember this cycle's level so the next cycle can compare against it.
    always_comb begin
        sig_d = i_sig;
    end

    // Level history register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign o_rise = i_sig & ~sig_q;
    assign o_fall = ~i_sig & sig_q;

endmodule

// File: rtl/bar_sweep_controller.sv
// Vertical inverted-bar sequencer: tracks active lines from the fvht flags, moves the bar
// start line once per frame and flags lines inside the bar window for the inversion mux.
module bar_sweep_controller
    import bar_sweep_pkg::*;
#(
    parameter int unsigned POS_W     = 11,
    parameter int unsigned MIN_POS   = DEF_MIN_POS,
    parameter int unsigned MAX_POS   = DEF_MAX_POS,
    parameter int unsigned RESET_POS = DEF_RESET_POS,
    parameter int unsigned STEP_W    = 4,
    parameter int unsigned HEIGHT_W  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [3:0]          i_fvht,
    input  logic                i_enable,
    input  logic                i_pause,
    input  logic [STEP_W-1:0]   i_step,
    input  logic [HEIGHT_W-1:0] i_bar_height,
    output logic                o_modify_period,
    output logic [POS_W-1:0]    o_bar_pos,
    output logic                o_dir_down,
    output logic [POS_W-1:0]    o_line_count,
    output logic                o_frame_tick
);

    localparam logic [POS_W-1:0]    MinPos     = POS_W'(MIN_POS);
    localparam logic [POS_W-1:0]    MaxPos     = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0]    ResetPos   = POS_W'(RESET_POS);
    localparam logic [STEP_W-1:0]   DefStep    = STEP_W'(DEF_SHADOW_STEP);
    localparam logic [HEIGHT_W-1:0] DefHeight  = HEIGHT_W'(DEF_SHADOW_HEIGHT);
    localparam logic [POS_W-1:0]    LineMax    = '1;

    logic v_rise, v_fall, h_rise, h_fall_unused;
    logic vblank;
    logic unused_fvht;

    sweep_state_e          state_q, state_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic                  dir_q, dir_d;
    logic [POS_W-1:0]      line_q, line_d;
    logic                  modify_q, modify_d;
    logic                  tick_q, tick_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [HEIGHT_W-1:0]   height_q, height_d;

    logic [POS_W:0]        step_x, height_x, up_sum, down_lim, win_end;

    assign vblank      = i_fvht[FVHT_V_BIT];
    assign unused_fvht = i_fvht[3] ^ i_fvht[0];

    sync_edge_detect u_vblank_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sig  (vblank),
        .o_rise (v_rise),
        .o_fall (v_fall)
    );

    sync_edge_detect u_hblank_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sig  (i_fvht[FVHT_H_BIT]),
        .o_rise (h_rise),
        .o_fall (h_fall_unused)
    );

    // Widened arithmetic so bound checks and the window end never wrap.
    always_comb begin
        step_x   = {{(POS_W + 1 - STEP_W){1'b0}}, step_q};
        height_x = {{(POS_W + 1 - HEIGHT_W){1'b0}}, height_q};
        up_sum   = {1'b0, pos_q} + step_x;
        down_lim = {1'b0, MinPos} + step_x;
        win_end  = {1'b0, pos_q} + height_x;
    end

    // Frame sequencing, line counting, end-of-frame sweep and window decode.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        line_d   = line_q;
        tick_d   = 1'b0;
        step_d   = step_q;
        height_d = height_q;

        unique case (state_q)
            StSync: begin
                line_d = '0;
                if (vblank) begin
                    state_d = StBlank;
                end
            end
            StBlank: begin
                line_d = '0;
                if (v_fall) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (v_rise) begin
                    // Frame end wins over a coincident hblank edge.
                    state_d  = StBlank;
                    line_d   = '0;
                    tick_d   = 1'b1;
                    step_d   = i_step;
                    height_d = i_bar_height;
                    if (i_enable && !i_pause && (step_q != '0)) begin
                        if (!dir_q) begin
                            if (up_sum >= {1'b0, MaxPos}) begin
                                pos_d = MaxPos;
                                dir_d = 1'b1;
                            end else begin
                                pos_d = up_sum[POS_W-1:0];
                            end
                        end else if ({1'b0, pos_q} <= down_lim) begin
                            pos_d = MinPos;
                            dir_d = 1'b0;
                        end else begin
                            pos_d = pos_q - step_x[POS_W-1:0];
                        end
                    end
                end else if (h_rise && (line_q != LineMax)) begin
                    line_d = line_q + POS_W'(1);
                end
            end
            default: begin
                state_d = StSync;
                line_d  = '0;
            end
        endcase

        // Gate on the next state so the select drops together with the frame end.
        modify_d = (state_d == StActive) && i_enable && (line_q >= pos_q)
                   && ({1'b0, line_q} < win_end);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StSync;
            pos_q    <= ResetPos;
            dir_q    <= 1'b0;
            line_q   <= '0;
            modify_q <= 1'b0;
            tick_q   <= 1'b0;
            step_q   <= DefStep;
            height_q <= DefHeight;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            line_q   <= line_d;
            modify_q <= modify_d;
            tick_q   <= tick_d;
            step_q   <= step_d;
            height_q <= height_d;
        end
    end

    assign o_modify_period = modify_q;
    assign o_bar_pos       = pos_q;
    assign o_dir_down      = dir_q;
    assign o_line_count    = line_q;
    assign o_frame_tick    = tick_q;

endmodule

// File: tb/tb_bar_sweep_controller.sv
// Self-checking bench for bar_sweep_controller, using a frame/line level reference model.
module tb_bar_sweep_controller;

    localparam int POS_W    = 11;
    localparam int LINE_MAX = 2047;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [3:0]  i_fvht;
    logic        i_enable;
    logic        i_pause;
    logic [3:0]  i_step;
    logic [7:0]  i_bar_height;
    logic        o_modify_period;
    logic [10:0] o_bar_pos;
    logic        o_dir_down;
    logic [10:0] o_line_count;
    logic        o_frame_tick;

    always #5 clk = ~clk;

    bar_sweep_controller dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_fvht          (i_fvht),
        .i_enable        (i_enable),
        .i_pause         (i_pause),
        .i_step          (i_step),
        .i_bar_height    (i_bar_height),
        .o_modify_period (o_modify_period),
        .o_bar_pos       (o_bar_pos),
        .o_dir_down      (o_dir_down),
        .o_line_count    (o_line_count),
        .o_frame_tick    (o_frame_tick)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0 = waiting for first vblank, 1 = blank, 2 = active.
    int m_state, m_pos, m_dir, m_sh_step, m_sh_height;
    int la = 2, hb = 3, vb = 3;
    int mid_line = -1, mid_height = 8, mid_step = 1;
    logic mid_enable = 1'b1;
    int win_hits;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void sweep(input int pos, input int dir, input int s, input logic en,
                                  input logic pa, output int npos, output int ndir);
        npos = pos;
        ndir = dir;
        if (en && !pa && s != 0) begin
            if (dir == 0) begin
                if (pos + s >= 1024) begin npos = 1024; ndir = 1; end
                else npos = pos + s;
            end else if (pos <= 1 + s) begin
                npos = 1; ndir = 0;
            end else begin
                npos = pos - s;
            end
        end
    endfunction

    function automatic logic in_win(input int line);
        return i_enable && (line >= m_pos) && (line < m_pos + m_sh_height);
    endfunction

    function automatic int sat(input int v);
        return (v > LINE_MAX) ? LINE_MAX : v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pos = 2; m_dir = 0; m_sh_step = 1; m_sh_height = 8;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_fvht = 4'b0000;
        tick();
        tick();
        i_rst = 1'b0;
        model_reset();
    endtask

    // Vertical blank (ending any active frame), then nlines active lines. With coincide set,
    // the last line's hblank rise is left for the next frame's vblank rise.
    task automatic run_frame(input int nlines, input logic coincide);
        int np, nd;
        logic exp_tick, exp_mod;
        win_hits = 0;
        i_fvht = 4'b0110;
        tick();
        exp_tick = (m_state == 2);
        if (m_state == 2) begin
            sweep(m_pos, m_dir, m_sh_step, i_enable, i_pause, np, nd);
            m_pos = np;
            m_dir = nd;
            m_sh_step = int'(i_step);
            m_sh_height = int'(i_bar_height);
        end
        m_state = 1;
        n_vec++; if (o_frame_tick !== exp_tick) begin n_err++;
            $display("FAIL frame_tick: got %b want %b", o_frame_tick, exp_tick); end
        n_vec++; if (o_bar_pos !== POS_W'(m_pos)) begin n_err++;
            $display("FAIL frame_pos: got %0d want %0d", o_bar_pos, m_pos); end
        n_vec++; if (o_dir_down !== 1'(m_dir)) begin n_err++;
            $display("FAIL frame_dir: got %b want %0d", o_dir_down, m_dir); end
        n_vec++; if (o_line_count !== 11'd0) begin n_err++;
            $display("FAIL frame_end_count: got %0d want 0", o_line_count); end
        n_vec++; if (o_modify_period !== 1'b0) begin n_err++;
            $display("FAIL blank_window: got %b want 0", o_modify_period); end
        for (int c = 1; c < vb; c++) begin
            tick();
            n_vec++; if (o_frame_tick !== 1'b0 || o_modify_period !== 1'b0) begin n_err++;
                $display("FAIL blank_quiet: tick %b window %b want 0 0", o_frame_tick,
                         o_modify_period); end
        end
        i_fvht = 4'b0010;
        tick();
        m_state = 2;
        for (int i = 1; i <= nlines; i++) begin
            if (i == mid_line) begin
                i_bar_height = 8'(mid_height);
                i_step = 4'(mid_step);
                i_enable = mid_enable;
            end
            i_fvht = 4'b0000;
            tick();
            exp_mod = in_win(i - 1);
            if (o_modify_period === 1'b1) win_hits++;
            n_vec++; if (o_modify_period !== exp_mod) begin n_err++;
                $display("FAIL line_window: count %0d got %b want %b", i - 1, o_modify_period,
                         exp_mod); end
            n_vec++; if (o_line_count !== POS_W'(sat(i - 1))) begin n_err++;
                $display("FAIL line_count: got %0d want %0d", o_line_count, sat(i - 1)); end
            for (int c = 1; c < la; c++) tick();
            if (coincide && i == nlines) break;
            i_fvht = 4'b0010;
            tick();
            n_vec++; if (o_line_count !== POS_W'(sat(i))) begin n_err++;
                $display("FAIL line_incr: got %0d want %0d", o_line_count, sat(i)); end
            for (int c = 1; c < hb; c++) tick();
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_fvht = 4'b0000; i_enable = 1'b1; i_pause = 1'b0;
        i_step = 4'd1; i_bar_height = 8'd8;
        tick();
        tick();
        n_vec++; if (o_bar_pos !== 11'd2 || o_dir_down !== 1'b0) begin n_err++;
            $display("FAIL reset_pos: pos %0d dir %b want 2 0", o_bar_pos, o_dir_down); end
        n_vec++; if (o_line_count !== 11'd0 || o_modify_period !== 1'b0 || o_frame_tick !== 1'b0)
            begin n_err++;
            $display("FAIL reset_outs: count %0d window %b tick %b want 0 0 0", o_line_count,
                     o_modify_period, o_frame_tick); end
        i_rst = 1'b0;
        model_reset();
        // Partial frame before any vblank must be ignored.
        for (int i = 0; i < 5; i++) begin
            i_fvht = 4'b0000; tick(); tick();
            i_fvht = 4'b0010; tick();
            n_vec++; if (o_line_count !== 11'd0 || o_modify_period !== 1'b0 || o_frame_tick !== 1'b0)
                begin n_err++;
                $display("FAIL presync_idle: count %0d window %b tick %b", o_line_count,
                         o_modify_period, o_frame_tick); end
            tick();
        end
        run_frame(20, 1'b0);
        run_frame(20, 1'b0);
        n_vec++; if (o_bar_pos !== 11'd3) begin n_err++;
            $display("FAIL first_sweep: got %0d want 3", o_bar_pos); end
        run_frame(20, 1'b0);
        n_vec++; if (o_bar_pos !== 11'd4) begin n_err++;
            $display("FAIL second_sweep: got %0d want 4", o_bar_pos); end
    endtask

    task automatic test_window();
        do_reset();
        i_step = 4'd1; i_bar_height = 8'd8;
        run_frame(20, 1'b0);
        n_vec++; if (win_hits != 8) begin n_err++;
            $display("FAIL window_span: got %0d lines want 8", win_hits); end
    endtask

    task automatic test_top_bound();
        int pn, nd;
        i_step = 4'd15;
        for (int k = 0; k < 100; k++) begin
            sweep(m_pos, m_dir, m_sh_step, i_enable, i_pause, pn, nd);
            if (nd == 0 && pn <= 1020 && 1020 - pn <= 15) begin
                i_step = 4'(1020 - pn);
                run_frame(2, 1'b0);
                break;
            end
            run_frame(2, 1'b0);
        end
        i_step = 4'd15;
        run_frame(2, 1'b0);
        n_vec++; if (o_bar_pos !== 11'd1020) begin n_err++;
            $display("FAIL top_approach: got %0d want 1020", o_bar_pos); end
        run_frame(2, 1'b0);
        n_vec++; if (o_bar_pos !== 11'd1024 || o_dir_down !== 1'b1) begin n_err++;
            $display("FAIL top_clamp: pos %0d dir %b want 1024 1", o_bar_pos, o_dir_down); end
        run_frame(2, 1'b0);
        n_vec++; if (o_bar_pos !== 11'd1009) begin n_err++;
            $display("FAIL top_return: got %0d want 1009", o_bar_pos); end
    endtask

    task automatic test_bottom_bound();
        int pn, nd;
        i_step = 4'd15;
        for (int k = 0; k < 100; k++) begin
            sweep(m_pos, m_dir, m_sh_step, i_enable, i_pause, pn, nd);
            if (nd == 1 && pn > 5 && pn - 5 <= 15) begin
                i_step = 4'(pn - 5);
                run_frame(2, 1'b0);
                break;
            end
            run_frame(2, 1'b0);
        end
        i_step = 4'd4;
        run_frame(2, 1'b0);
        n_vec++; if (o_bar_pos !== 11'd5 || o_dir_down !== 1'b1) begin n_err++;
            $display("FAIL bottom_approach: pos %0d dir %b want 5 1", o_bar_pos, o_dir_down); end
        run_frame(2, 1'b0);
        n_vec++; if (o_bar_pos !== 11'd1 || o_dir_down !== 1'b0) begin n_err++;
            $display("FAIL bottom_clamp: pos %0d dir %b want 1 0", o_bar_pos, o_dir_down); end
        run_frame(2, 1'b0);
        n_vec++; if (o_bar_pos !== 11'd5 || o_dir_down !== 1'b0) begin n_err++;
            $display("FAIL bottom_return: pos %0d dir %b want 5 0", o_bar_pos, o_dir_down); end
    endtask

    task automatic test_config_enable();
        i_step = 4'd4; i_bar_height = 8'd8;
        run_frame(30, 1'b0);
        n_vec++; if (win_hits != 8) begin n_err++;
            $display("FAIL cfg_base_span: got %0d want 8", win_hits); end
        mid_line = 5; mid_height = 3; mid_step = 2; mid_enable = 1'b1;
        run_frame(30, 1'b0);
        n_vec++; if (win_hits != 8) begin n_err++;
            $display("FAIL cfg_midframe_height: got %0d want 8", win_hits); end
        mid_line = -1;
        run_frame(30, 1'b0);
        n_vec++; if (win_hits != 3) begin n_err++;
            $display("FAIL cfg_new_height: got %0d want 3", win_hits); end
        mid_line = 21; mid_height = 3; mid_step = 2; mid_enable = 1'b0;
        run_frame(30, 1'b0);
        mid_line = -1;
        n_vec++; if (win_hits != 1) begin n_err++;
            $display("FAIL enable_drop_span: got %0d want 1", win_hits); end
        run_frame(30, 1'b0);
        n_vec++; if (o_bar_pos !== 11'd19) begin n_err++;
            $display("FAIL enable_freeze: got %0d want 19", o_bar_pos); end
        i_enable = 1'b1;
    endtask

    task automatic test_coincide_reset();
        logic exp_mod;
        i_bar_height = 8'd8; i_step = 4'd2;
        run_frame(25, 1'b1);
        n_vec++; if (o_line_count !== 11'd24) begin n_err++;
            $display("FAIL coincide_pre_count: got %0d want 24", o_line_count); end
        run_frame(30, 1'b0);
        i_fvht = 4'b0000;
        tick();
        exp_mod = in_win(30);
        n_vec++; if (o_modify_period !== exp_mod) begin n_err++;
            $display("FAIL prereset_window: got %b want %b", o_modify_period, exp_mod); end
        #2;
        i_rst = 1'b1;
        #1;
        n_vec++; if (o_modify_period !== 1'b0 || o_bar_pos !== 11'd2 || o_dir_down !== 1'b0)
            begin n_err++;
            $display("FAIL midframe_reset: window %b pos %0d dir %b want 0 2 0",
                     o_modify_period, o_bar_pos, o_dir_down); end
        n_vec++; if (o_line_count !== 11'd0 || o_frame_tick !== 1'b0) begin n_err++;
            $display("FAIL midframe_reset_count: count %0d tick %b want 0 0", o_line_count,
                     o_frame_tick); end
        model_reset();
        tick();
        tick();
        i_rst = 1'b0;
        i_step = 4'd1; i_bar_height = 8'd8;
        run_frame(12, 1'b0);
        run_frame(12, 1'b0);
        n_vec++; if (o_bar_pos !== 11'd3) begin n_err++;
            $display("FAIL resync_sweep: got %0d want 3", o_bar_pos); end
    endtask

    task automatic test_saturation();
        la = 1; hb = 1;
        run_frame(2050, 1'b0);
        la = 2; hb = 3;
        n_vec++; if (o_line_count !== 11'd2047) begin n_err++;
            $display("FAIL count_saturate: got %0d want 2047", o_line_count); end
    endtask

    task automatic test_random();
        int nl;
        for (int f = 0; f < 30; f++) begin
            nl = int'($urandom_range(1, 24));
            i_step = 4'($urandom_range(0, 15));
            i_bar_height = 8'($urandom_range(0, 255));
            i_enable = ($urandom_range(0, 7) != 0);
            i_pause = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1) begin
                mid_line = int'($urandom_range(1, 24));
                mid_height = int'($urandom_range(0, 20));
                mid_step = int'($urandom_range(0, 15));
                mid_enable = ($urandom_range(0, 3) != 0);
            end else begin
                mid_line = -1;
            end
            run_frame(nl, ($urandom_range(0, 3) == 0));
        end
        mid_line = -1;
        i_enable = 1'b1; i_pause = 1'b0;
        run_frame(4, 1'b0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_window();
        test_top_bound();
        test_bottom_bound();
        test_config_enable();
        test_coincide_reset();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
